// File: rtl/mips_reg_dump.sv
// Post-halt register-file dump engine: walks R0..R(NREGS-1) over a sync read port onto a valid/ready stream.
// Optional trailing XOR checksum word is enabled with `define DUMP_CHECKSUM_EN.
module mips_reg_dump #(
  parameter int NREGS = 32
) (
  input  logic        clk1,
  input  logic        rst,
  input  logic        halted,
  input  logic        start,
  output logic        reg_rd_en,
  output logic [4:0]  reg_addr,
  input  logic [31:0] reg_rdata,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [31:0] tx_data,
  output logic        tx_last,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {IDLE, RD, SEND, CSUM, DONE} state_t;

  localparam logic [4:0] LAST_IDX = 5'(NREGS - 1);

  state_t      state_q, state_d;
  logic [4:0]  idx_q, idx_d;
  logic        halted_q, halted_d;
  logic        armed_q, armed_d;
  logic        fresh_q, fresh_d;
  logic [31:0] data_q, data_d;
  logic        rd_en_q, rd_en_d;
  logic [4:0]  addr_q, addr_d;
  logic        valid_q, valid_d;
  logic        last_q, last_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        trigger;
  logic        handshake;
  logic [31:0] word;
`ifdef DUMP_CHECKSUM_EN
  logic [31:0] acc_q, acc_d;
`endif

  // The read data only arrives in the first SEND cycle, so it is forwarded
  // directly then and held in data_q for any stalled cycles that follow.
  assign word = fresh_q ? reg_rdata : data_q;

  // armed_q suppresses a false edge when halted is already high at reset release.
  assign trigger   = (halted & ~halted_q & armed_q) | start;
  assign handshake = valid_q & tx_ready;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    halted_d = halted;
    armed_d  = 1'b1;
    fresh_d  = 1'b0;
    data_d   = data_q;
`ifdef DUMP_CHECKSUM_EN
    acc_d    = acc_q;
`endif
    case (state_q)
      IDLE: begin
        if (trigger) begin
          state_d = RD;
          idx_d   = 5'd0;
`ifdef DUMP_CHECKSUM_EN
          acc_d   = 32'd0;
`endif
        end
      end
      RD: begin
        state_d = SEND;
        fresh_d = 1'b1;
      end
      SEND: begin
        data_d = word;
        if (handshake) begin
`ifdef DUMP_CHECKSUM_EN
          acc_d = acc_q ^ word;
`endif
          if (idx_q == LAST_IDX) begin
`ifdef DUMP_CHECKSUM_EN
            state_d = CSUM;
`else
            state_d = DONE;
`endif
          end else begin
            idx_d   = idx_q + 5'd1;
            state_d = RD;
          end
        end
      end
      CSUM: begin
        if (handshake) state_d = DONE;
      end
      DONE: begin
        if (!halted && !start) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they leave the flops cleanly.
    rd_en_d = (state_d == RD);
    addr_d  = (state_d == RD) ? idx_d : addr_q;
    valid_d = (state_d == SEND) || (state_d == CSUM);
`ifdef DUMP_CHECKSUM_EN
    last_d  = (state_d == CSUM);
`else
    last_d  = (state_d == SEND) && (idx_d == LAST_IDX);
`endif
    busy_d  = (state_d == RD) || (state_d == SEND) || (state_d == CSUM);
    done_d  = (state_d == DONE);
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= 5'd0;
      halted_q <= 1'b0;
      armed_q  <= 1'b0;
      fresh_q  <= 1'b0;
      data_q   <= 32'd0;
      rd_en_q  <= 1'b0;
      addr_q   <= 5'd0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
      acc_q    <= 32'd0;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      halted_q <= halted_d;
      armed_q  <= armed_d;
      fresh_q  <= fresh_d;
      data_q   <= data_d;
      rd_en_q  <= rd_en_d;
      addr_q   <= addr_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef DUMP_CHECKSUM_EN
      acc_q    <= acc_d;
`endif
    end
  end

  assign reg_rd_en = rd_en_q;
  assign reg_addr  = addr_q;
  assign tx_valid  = valid_q;
  assign tx_last   = last_q;
  assign busy      = busy_q;
  assign done      = done_q;
`ifdef DUMP_CHECKSUM_EN
  assign tx_data   = (state_q == CSUM) ? acc_q : word;
`else
  assign tx_data   = word;
`endif

endmodule
